// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: arbiter state encoding, data width, clog2 helper
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_ACTIVE = 2'd1,
        ST_WAIT_DONE   = 2'd2,
        ST_GUARD       = 2'd3
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker: rotate, find-first-one, unrotate
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_valid,
    output logic [W-1:0] o_idx
);

    logic [N-1:0] w_rot;
    logic [W-1:0] w_off;
    logic         w_found;
    int           w_sum;

    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N; j++) begin
            w_sum = int'(i_ptr) + j;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_rot[j] = i_req[W'(w_sum)];
        end

        w_found = 1'b0;
        w_off   = '0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_off   = W'(j);
            end
        end

        w_sum = int'(i_ptr) + int'(w_off);
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        o_valid = w_found;
        o_idx   = W'(w_sum);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx between NUM_REQ byte producers
import uart_pkg::*;

module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ACTIVE_TIMEOUT = 16,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [8*NUM_REQ-1:0]          i_req_byte,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_done,
    output logic                          o_error,
    output logic                          o_busy,
    output logic [ID_W-1:0]               o_owner,
    output logic                          o_tx_dv,
    output logic [UART_DATA_BITS-1:0]     o_tx_byte,
    input  logic                          i_tx_active,
    input  logic                          i_tx_done
);

    localparam int CNT_W = clog2(ACTIVE_TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    arb_state_t                  r_state;
    arb_state_t                  w_state_next;
    logic [ID_W-1:0]             r_ptr;
    logic [CNT_W-1:0]            r_cnt;
    logic [NUM_REQ-1:0]          r_grant;
    logic [NUM_REQ-1:0]          r_done;
    logic                        r_error;
    logic                        r_tx_dv;
    logic [UART_DATA_BITS-1:0]   r_tx_byte;
    logic [ID_W-1:0]             r_owner;

    logic                        w_pick_valid;
    logic [ID_W-1:0]             w_pick_idx;
    logic                        w_timeout;
    logic                        w_issue;
    logic                        w_done_fire;
    logic                        w_err_fire;
    logic                        w_cnt_inc;

    rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_timeout = (r_cnt == CNT_W'(ACTIVE_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A done seen before active still completes the byte; timeout only when neither arrives.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) w_state_next = ST_WAIT_ACTIVE;
            end
            ST_WAIT_ACTIVE: begin
                if (i_tx_done)        w_state_next = ST_GUARD;
                else if (i_tx_active) w_state_next = ST_WAIT_DONE;
                else if (w_timeout)   w_state_next = ST_GUARD;
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) w_state_next = ST_GUARD;
            end
            ST_GUARD: begin
                if (!i_tx_active && !i_tx_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue     = 1'b0;
        w_done_fire = 1'b0;
        w_err_fire  = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: w_issue = w_pick_valid;
            ST_WAIT_ACTIVE: begin
                if (i_tx_done)         w_done_fire = 1'b1;
                else if (!i_tx_active) begin
                    if (w_timeout) w_err_fire = 1'b1;
                    else           w_cnt_inc  = 1'b1;
                end
            end
            ST_WAIT_DONE: w_done_fire = i_tx_done;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_error   <= 1'b0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_owner   <= '0;
        end else begin
            r_grant <= '0;
            r_tx_dv <= 1'b0;
            r_done  <= '0;
            r_error <= w_err_fire;
            if (w_issue) begin
                r_grant   <= ONE_HOT0 << w_pick_idx;
                r_tx_dv   <= 1'b1;
                r_tx_byte <= i_req_byte[w_pick_idx*8 +: 8];
                r_owner   <= w_pick_idx;
                r_ptr     <= (w_pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
                r_cnt     <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done_fire) begin
                r_done <= ONE_HOT0 << r_owner;
            end
        end
    end

    assign o_grant   = r_grant;
    assign o_done    = r_done;
    assign o_error   = r_error;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_owner   = r_owner;
    assign o_tx_dv   = r_tx_dv;
    assign o_tx_byte = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a compact uart_tx/rx line model
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int BIT   = 4;
    localparam int FRAME = 10 * BIT;

    typedef struct {
        int         id;
        logic [7:0] b;
        logic       err;
        int         cyc;
    } item_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   i_req = '0;
    logic [8*NREQ-1:0] i_req_byte = '0;
    logic [NREQ-1:0]   o_grant;
    logic [NREQ-1:0]   o_done;
    logic              o_error;
    logic              o_busy;
    logic [1:0]        o_owner;
    logic              o_tx_dv;
    logic [7:0]        o_tx_byte;

    logic       m_active;
    logic       m_done;
    logic       m_dead = 1'b0;
    int         m_cnt;
    int         m_bit;
    logic       m_line;
    logic [7:0] rx_byte = '0;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    item_t exp_q[$];
    item_t fly_q[$];
    logic  prev_grant = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(
        .NUM_REQ        (NREQ),
        .ACTIVE_TIMEOUT (16)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_req       (i_req),
        .i_req_byte  (i_req_byte),
        .o_grant     (o_grant),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_busy      (o_busy),
        .o_owner     (o_owner),
        .o_tx_dv     (o_tx_dv),
        .o_tx_byte   (o_tx_byte),
        .i_tx_active (m_active),
        .i_tx_done   (m_done)
    );

    // uart_tx stand-in: drives the line from the live o_tx_byte so any instability corrupts rx_byte
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_cnt    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_cnt == FRAME - 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (o_tx_dv && !m_dead && !m_done) begin
                m_active <= 1'b1;
                m_cnt    <= 0;
            end
        end
    end

    always_comb begin
        m_bit  = m_cnt / BIT;
        m_line = 1'b1;
        if (m_active) begin
            if (m_bit == 0)      m_line = 1'b0;
            else if (m_bit <= 8) m_line = o_tx_byte[3'(m_bit - 1)];
        end
    end

    always @(posedge clk) begin
        if (m_active && (m_cnt % BIT) == BIT / 2 && m_bit >= 1 && m_bit <= 8)
            rx_byte[3'(m_bit - 1)] <= m_line;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        item_t e;
        if (rstn) begin
            if (prev_grant) chk("grant_pulse_width", {28'd0, o_grant, o_tx_dv}, 32'd0);
            if (o_grant != '0) begin
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", {28'd0, o_grant}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", {28'd0, o_grant}, 32'd1 << e.id);
                    chk("tx_byte", {24'd0, o_tx_byte}, {24'd0, e.b});
                    chk("owner", {30'd0, o_owner}, e.id);
                    chk("dv_with_grant", {31'd0, o_tx_dv}, 32'd1);
                    chk("dv_while_uart_busy", {31'd0, m_active | m_done}, 32'd0);
                    e.cyc = cyc;
                    fly_q.push_back(e);
                end
            end
            if (m_done && fly_q.size() != 0)
                chk("rx_byte", {24'd0, rx_byte}, {24'd0, fly_q[0].b});
            if (o_done != '0) begin
                if (fly_q.size() == 0) begin
                    chk("done_unexpected", {28'd0, o_done}, 32'd0);
                end else begin
                    e = fly_q.pop_front();
                    chk("done", {28'd0, o_done}, 32'd1 << e.id);
                    chk("done_not_after_timeout", {31'd0, e.err}, 32'd0);
                end
            end
            if (o_error) begin
                if (fly_q.size() == 0) begin
                    chk("error_unexpected", 32'd1, 32'd0);
                end else begin
                    e = fly_q.pop_front();
                    chk("error_expected", {31'd0, e.err}, 32'd1);
                    chk("error_latency", cyc - e.cyc, 32'd16);
                end
            end
        end
        prev_grant <= (o_grant != '0);
    end

    task automatic step();
        @(negedge clk);
        i_req = i_req & ~o_grant;
    endtask

    task automatic push(input int id, input logic [7:0] b);
        item_t e;
        e.id  = id;
        e.b   = b;
        e.err = m_dead;
        e.cyc = 0;
        i_req_byte[id*8 +: 8] = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_quiet(input string tag);
        int n;
        n = 0;
        step();
        while ((i_req != '0 || o_busy || exp_q.size() != 0 || fly_q.size() != 0) && n < 2000) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, n, (n < 2000) ? n : 0);
        chk({tag, "_busy_idle"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_scoreboard_empty"}, exp_q.size() + fly_q.size(), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, {28'd0, o_grant}, 32'd0);
        chk({tag, "_done"}, {28'd0, o_done}, 32'd0);
        chk({tag, "_error"}, {31'd0, o_error}, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_owner"}, {30'd0, o_owner}, 32'd0);
        chk({tag, "_tx_dv"}, {31'd0, o_tx_dv}, 32'd0);
        chk({tag, "_tx_byte"}, {24'd0, o_tx_byte}, 32'd0);
        chk({tag, "_line_idle"}, {31'd0, m_line}, 32'd1);
    endtask

    initial begin
        int n;

        // reset held with every requester asserted, then round-robin from 0 and a wrap back to 0
        i_req = 4'hF;
        push(0, 8'h10);
        push(1, 8'h11);
        push(2, 8'h12);
        push(3, 8'h13);
        repeat (4) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        wait_quiet("fair");
        push(0, 8'h10);
        i_req = 4'b0001;
        wait_quiet("fair_wrap");

        push(2, 8'hA1);
        i_req = 4'b0100;
        wait_quiet("single");

        push(3, 8'h77);
        i_req = 4'b1000;
        wait_quiet("ptr_to3");
        push(0, 8'h5A);
        push(3, 8'hC3);
        i_req = 4'b1001;
        wait_quiet("ptr_wrap");

        m_dead = 1'b1;
        push(1, 8'hEE);
        i_req = 4'b0010;
        wait_quiet("timeout");
        m_dead = 1'b0;
        push(2, 8'h42);
        i_req = 4'b0100;
        wait_quiet("after_timeout");

        // reset lands asynchronously during data bit 4 of 8'h55
        push(3, 8'h55);
        i_req = 4'b1000;
        n = 0;
        step();
        while (!(m_active && m_cnt == 5 * BIT + 1) && n < 500) begin
            step();
            n++;
        end
        chk("midframe_reach", n, (n < 500) ? n : 0);
        #2 rstn = 1'b0;
        #1 chk_all_zero("midframe_reset");
        exp_q.delete();
        fly_q.delete();
        i_req = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        push(1, 8'h3C);
        push(3, 8'hA5);
        i_req = 4'b1010;
        wait_quiet("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
